// File: rtl/calc_port_responder_pkg.sv
// Shared types and widths for the calc request/response port.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package calc_port_responder_pkg;

    localparam int CALC_CMD_WIDTH  = 4;
    localparam int CALC_DATA_WIDTH = 32;

    typedef enum logic [CALC_CMD_WIDTH-1:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } calc_cmd_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        OK   = 2'b01,
        ERR  = 2'b10,
        RSVD = 2'b11
    } calc_resp_e;

    typedef struct packed {
        logic [CALC_CMD_WIDTH-1:0]  cmd;
        logic [CALC_DATA_WIDTH-1:0] op1;
        logic [CALC_DATA_WIDTH-1:0] op2;
        logic [1:0]                 tag;
    } calc_req_t;

    function automatic logic is_shift_cmd(input logic [CALC_CMD_WIDTH-1:0] cmd);
        return (cmd == SHL) || (cmd == SHR);
    endfunction

endpackage

// File: rtl/calc_port_responder_if.sv
// Request/response bundle between a calc master and one responder port.
// Latency: wires only.
// Backpressure: none on the wire; the responder reports drops on 'drop'.
interface calc_port_responder_if
    import calc_port_responder_pkg::*;
#(
    parameter int DATA_W = CALC_DATA_WIDTH,
    parameter int CMD_W  = CALC_CMD_WIDTH
);
    logic [CMD_W-1:0]  req_cmd_in;
    logic [DATA_W-1:0] req_data_in;
    logic [1:0]        req_tag_in;
    logic [1:0]        out_resp;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_tag;
    logic              busy;
    logic              drop;

    modport master (
        output req_cmd_in, req_data_in, req_tag_in,
        input  out_resp, out_data, out_tag, busy, drop
    );

    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in,
        output out_resp, out_data, out_tag, busy, drop
    );
endinterface

// File: rtl/calc_port_responder_req_fifo.sv
// Synchronous request FIFO; storage is DEPTH entries of WIDTH bits.
// Latency: a pushed entry is visible at rd_dat on the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens on the same edge.
module calc_port_responder_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             PClk,
    input  logic             Rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign rd_dat  = mem[rd_ptr];

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge PClk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge PClk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/calc_port_responder.sv
// One calculator responder port: two-beat request ingress, in-order execute, pulsed response.
// Latency: response visible 3 edges after the cmd edge (+n edges for a shift by n).
// Backpressure: requests arriving at a full queue are discarded and flagged on drop.
module calc_port_responder
    import calc_port_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = CALC_DATA_WIDTH,
    parameter int CMD_W      = CALC_CMD_WIDTH
) (
    input  logic                  PClk,
    input  logic                  Rst,
    calc_port_responder_if.slave  port
);
    typedef enum logic {I_IDLE, I_OP2} in_state_e;
    typedef enum logic [1:0] {E_IDLE, E_SHIFT, E_RES} ex_state_e;

    // ---------------- ingress ----------------
    in_state_e         in_q, in_d;
    logic [CMD_W-1:0]  hold_cmd;
    logic [DATA_W-1:0] hold_op1;
    logic [1:0]        hold_tag;
    logic              push;
    calc_req_t         push_dat;

    // Ingress state register plus first-beat capture of cmd/op1/tag.
    always_ff @(posedge PClk) begin
        if (Rst) begin
            in_q     <= I_IDLE;
            hold_cmd <= '0;
            hold_op1 <= '0;
            hold_tag <= '0;
        end else begin
            in_q <= in_d;
            if (in_q == I_IDLE && port.req_cmd_in != '0) begin
                hold_cmd <= port.req_cmd_in;
                hold_op1 <= port.req_data_in;
                hold_tag <= port.req_tag_in;
            end
        end
    end

    // Ingress next state: second beat carries op2 and pushes the whole request.
    always_comb begin
        in_d = in_q;
        push = 1'b0;
        case (in_q)
            I_IDLE:  if (port.req_cmd_in != '0) in_d = I_OP2;
            I_OP2: begin
                push = 1'b1;
                in_d = I_IDLE;
            end
            default: in_d = I_IDLE;
        endcase
    end

    assign push_dat = '{cmd: hold_cmd, op1: hold_op1, op2: port.req_data_in, tag: hold_tag};

    // ---------------- queue ----------------
    calc_req_t head;
    logic      pop;
    logic      q_full;
    logic      q_empty;

    calc_port_responder_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(calc_req_t))
    ) u_fifo (
        .PClk   (PClk),
        .Rst    (Rst),
        .push   (push),
        .pop    (pop),
        .wr_dat (push_dat),
        .rd_dat (head),
        .full   (q_full),
        .empty  (q_empty)
    );

    // ---------------- execute ----------------
    ex_state_e         ex_q, ex_d;
    logic [CMD_W-1:0]  cur_cmd;
    logic [DATA_W-1:0] cur_op2;
    logic [1:0]        cur_tag;
    logic [DATA_W-1:0] acc;
    logic [4:0]        cnt;
    logic [4:0]        head_amt;

    assign head_amt = head.op2[4:0];

    // Exec next state: pop whenever idle or emitting, so queued work issues back to back.
    always_comb begin
        ex_d = ex_q;
        pop  = 1'b0;
        case (ex_q)
            E_IDLE, E_RES: begin
                if (!q_empty) begin
                    pop  = 1'b1;
                    ex_d = (is_shift_cmd(head.cmd) && head_amt != '0) ? E_SHIFT : E_RES;
                end else begin
                    ex_d = E_IDLE;
                end
            end
            E_SHIFT: if (cnt == 5'd1) ex_d = E_RES;
            default: ex_d = E_IDLE;
        endcase
    end

    // Exec state, working operands and the bit-serial shifter.
    always_ff @(posedge PClk) begin
        if (Rst) begin
            ex_q    <= E_IDLE;
            cur_cmd <= '0;
            cur_op2 <= '0;
            cur_tag <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            ex_q <= ex_d;
            if (pop) begin
                cur_cmd <= head.cmd;
                cur_op2 <= head.op2;
                cur_tag <= head.tag;
                acc     <= head.op1;
                cnt     <= head_amt;
            end else if (ex_q == E_SHIFT) begin
                acc <= (cur_cmd == SHL) ? {acc[DATA_W-2:0], 1'b0} : {1'b0, acc[DATA_W-1:1]};
                cnt <= cnt - 5'd1;
            end
        end
    end

    calc_resp_e        res_resp;
    logic [DATA_W-1:0] res_data;
    logic [DATA_W:0]   sum;

    // Result of the current request; errors always carry zero data.
    always_comb begin
        res_resp = ERR;
        res_data = '0;
        sum      = {1'b0, acc} + {1'b0, cur_op2};
        case (cur_cmd)
            ADD: if (!sum[DATA_W]) begin
                res_resp = OK;
                res_data = sum[DATA_W-1:0];
            end
            SUB: if (cur_op2 <= acc) begin
                res_resp = OK;
                res_data = acc - cur_op2;
            end
            SHL, SHR: begin
                res_resp = OK;
                res_data = acc;
            end
            default: ;
        endcase
    end

    // ---------------- output ----------------
    logic [1:0]        out_resp_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_tag_q;
    logic              drop_q;

    // Response register holds a result for exactly one cycle; drop pulses on a lost push.
    always_ff @(posedge PClk) begin
        if (Rst || ex_q != E_RES) begin
            out_resp_q <= NONE;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            out_resp_q <= res_resp;
            out_data_q <= res_data;
            out_tag_q  <= cur_tag;
        end
        drop_q <= !Rst && push && q_full && !pop;
    end

    assign port.out_resp = out_resp_q;
    assign port.out_data = out_data_q;
    assign port.out_tag  = out_tag_q;
    assign port.drop     = drop_q;
    assign port.busy     = !q_empty || (ex_q != E_IDLE);

endmodule

// File: tb/tb_calc_port_responder.sv
// Randomised and directed stimulus against a cycle-scheduled reference of the responder.
// Latency: checks every output every cycle against the scheduled expectation.
// Backpressure: the reference predicts queue occupancy and hence drops.
module tb_calc_port_responder;
    import calc_port_responder_pkg::*;

    localparam int DEPTH = 4;

    logic PClk = 1'b0;
    logic Rst  = 1'b1;
    always #5 PClk = ~PClk;

    calc_port_responder_if pif();

    calc_port_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .PClk (PClk),
        .Rst  (Rst),
        .port (pif.slave)
    );

    int cyc = 0;
    always @(posedge PClk) cyc <= cyc + 1;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    // Expected outputs keyed by the edge after which they must be visible.
    int          exp_resp [int];
    logic [31:0] exp_data [int];
    int          exp_tag  [int];
    bit          exp_drop [int];
    // Accepted requests: push edge, pop edge, response edge.
    int push_q [$];
    int pop_q  [$];
    int out_q  [$];
    int last_out = 0;
    int max_edge = 0;
    int exp_cnt  = 0;
    int seen     = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit model_busy(input int k);
        foreach (push_q[i]) if (push_q[i] <= k && k < out_q[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Request completes op2 at edge p: decide drop, else schedule its response.
    task automatic model_push(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                              input logic [1:0] tag, input int p);
        int occ = 0;
        bit popnow = 1'b0;
        int pop_e, out_e, n;
        int r;
        logic [31:0] d;
        longint unsigned s;
        foreach (push_q[i]) begin
            if (push_q[i] < p && pop_q[i] >= p) occ++;
            if (pop_q[i] == p) popnow = 1'b1;
        end
        if (occ >= DEPTH && !popnow) begin
            exp_drop[p] = 1'b1;
            if (p > max_edge) max_edge = p;
            return;
        end
        n = 0; r = 2; d = 32'd0;
        case (cmd)
            4'd1: begin
                s = longint'(op1) + longint'(op2);
                if (s <= 64'hFFFF_FFFF) begin r = 1; d = op1 + op2; end
            end
            4'd2: if (op2 <= op1) begin r = 1; d = op1 - op2; end
            4'd5: begin n = int'(op2 % 32); r = 1; d = op1 << n; end
            4'd6: begin n = int'(op2 % 32); r = 1; d = op1 >> n; end
            default: ;
        endcase
        pop_e = (p + 1 > last_out) ? p + 1 : last_out;
        out_e = pop_e + 1 + n;
        push_q.push_back(p);
        pop_q.push_back(pop_e);
        out_q.push_back(out_e);
        last_out = out_e;
        exp_resp[out_e] = r;
        exp_data[out_e] = d;
        exp_tag[out_e]  = (r == 0) ? 0 : int'(tag);
        exp_cnt++;
        if (out_e > max_edge) max_edge = out_e;
    endtask

    // Called just after a negedge; cmd edge is the next posedge, op2 the one after.
    task automatic send(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                        input logic [1:0] tag);
        pif.req_cmd_in  = cmd;
        pif.req_data_in = op1;
        pif.req_tag_in  = tag;
        @(negedge PClk);
        pif.req_cmd_in  = 4'd0;
        pif.req_data_in = op2;
        pif.req_tag_in  = 2'd0;
        model_push(cmd, op1, op2, tag, cyc + 1);
        @(negedge PClk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PClk);
    endtask

    // One-edge reset; everything due at or after the reset edge is forgotten.
    task automatic do_reset();
        int keys [$];
        int e;
        Rst = 1'b1;
        #1;
        e = cyc + 1;
        foreach (exp_resp[k]) if (k >= e) keys.push_back(k);
        foreach (keys[i]) begin
            exp_resp.delete(keys[i]);
            exp_data.delete(keys[i]);
            exp_tag.delete(keys[i]);
            exp_cnt--;
        end
        keys.delete();
        foreach (exp_drop[k]) if (k >= e) keys.push_back(k);
        foreach (keys[i]) exp_drop.delete(keys[i]);
        push_q.delete();
        pop_q.delete();
        out_q.delete();
        last_out = 0;
        @(negedge PClk);
        Rst = 1'b0;
    endtask

    // Per-cycle monitor: every output against the schedule for the edge just passed.
    always @(negedge PClk) begin
        int k;
        if (chk_en) begin
            k = cyc;
            chk("resp", 64'(pif.out_resp), exp_resp.exists(k) ? 64'(exp_resp[k]) : 64'd0);
            chk("data", 64'(pif.out_data), exp_data.exists(k) ? 64'(exp_data[k]) : 64'd0);
            chk("tag",  64'(pif.out_tag),  exp_tag.exists(k)  ? 64'(exp_tag[k])  : 64'd0);
            chk("drop", 64'(pif.drop),     exp_drop.exists(k) ? 64'd1 : 64'd0);
            chk("busy", 64'(pif.busy),     64'(model_busy(k)));
            if (pif.out_resp != 2'b00) seen++;
        end
    end

    logic [3:0]  cmd_pool [8] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b, r;
        pif.req_cmd_in  = 4'd0;
        pif.req_data_in = 32'd0;
        pif.req_tag_in  = 2'd0;
        Rst = 1'b1;
        repeat (3) @(negedge PClk);
        Rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // basic add with base latency
        send(4'd1, 32'd5, 32'd7, 2'd2);
        idle(6);

        // error cases, back to back
        send(4'd1, 32'hFFFF_FFFF, 32'd1, 2'd0);
        send(4'd2, 32'd3, 32'd4, 2'd3);
        send(4'd3, 32'd9, 32'd9, 2'd1);
        idle(6);

        // long left shift, then zero-amount right shift
        send(4'd5, 32'd1, 32'd31, 2'd1);
        idle(40);
        send(4'd6, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 2'd3);
        idle(6);

        // fill the queue behind a long shift; fifth add is dropped
        send(4'd5, 32'd3, 32'd31, 2'd0);
        for (int i = 0; i < 5; i++) send(4'd1, 32'(i * 10), 32'd1, 2'(i));
        idle(50);

        // reset while shifting with work queued
        send(4'd5, 32'd1, 32'd20, 2'd2);
        for (int i = 0; i < 3; i++) send(4'd1, 32'd100, 32'(i), 2'(i));
        idle(4);
        do_reset();
        idle(40);
        send(4'd1, 32'd40, 32'd2, 2'd1);
        idle(6);

        // full queue where a push lands on the pop edge
        begin
            int e0;
            e0 = cyc + 1;
            send(4'd5, 32'h0000_0011, 32'd31, 2'd3);
            for (int i = 0; i < 4; i++) send(4'd2, 32'd50, 32'(i), 2'(i));
            while (cyc + 1 < e0 + 33) @(negedge PClk);
            send(4'd1, 32'd7, 32'd8, 2'd2);
        end
        idle(20);

        // randomised traffic
        for (int i = 0; i < 40; i++) begin
            c = cmd_pool[$urandom_range(0, 7)];
            a = $urandom();
            r = $urandom();
            case (c)
                4'd5, 4'd6: b = {r[31:5], 5'($urandom_range(0, 9))};
                4'd2:       b = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 1000));
                default:    b = ($urandom_range(0, 1) != 0) ? r : 32'($urandom_range(0, 100));
            endcase
            send(c, a, b, 2'($urandom_range(0, 3)));
            idle($urandom_range(0, 3));
        end

        for (int i = 0; i < 5000 && cyc <= max_edge + 2; i++) @(negedge PClk);
        chk("drained", 64'(cyc > max_edge + 2), 64'd1);
        chk("resp_count", 64'(seen), 64'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
